// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: programmable 64-bit performance counters with multi-count events,
// threshold crossing detection and a valid/ready sampling request towards the sampler.
// Optional feature macro: HPM_SAMPLING_EN (thresholds, pending bits, sampler FSM).
// Ports: clk_i/rst_i (async active-high), debug_mode_i freezes counting,
// addr_i/we_i/data_i/data_o/access_err_o register port (addr_i[7:5] region, [4:0] index),
// event_inc_i per-event increments, inhibit_i per-counter inhibit,
// sample_valid_o/sample_ready_i/sample_id_o/sample_value_o sampling handshake.
module hpm_counter_bank #(
    parameter int unsigned NumCounters   = 6,
    parameter int unsigned NumEvents     = 32,
    parameter int unsigned IncWidth      = 2,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned HoldoffCycles = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          debug_mode_i,
    input  logic [7:0]                    addr_i,
    input  logic                          we_i,
    input  logic [DataWidth-1:0]          data_i,
    output logic [DataWidth-1:0]          data_o,
    output logic                          access_err_o,
    input  logic [NumEvents*IncWidth-1:0] event_inc_i,
    input  logic [NumCounters-1:0]        inhibit_i,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    output logic [4:0]                    sample_id_o,
    output logic [63:0]                   sample_value_o
);
    localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;

    logic [2:0]             region;
    logic [4:0]             idx;
    logic                   idx_ok, wr;
    logic [63:0]            din, rd;
    logic [64:0]            sum;
    logic [63:0]            cnt_q [NumCounters];
    logic [63:0]            cnt_d [NumCounters];
    logic [SelW-1:0]        sel_q [NumCounters];
    logic [SelW-1:0]        sel_d [NumCounters];
    logic [IncWidth-1:0]    inc   [NumCounters];
    logic [63:0]            thr   [NumCounters];
    logic [NumCounters-1:0] wrap_q, wrap_d, wrap_ev, pend;

    assign region = addr_i[7:5];
    assign idx    = addr_i[4:0];
    assign idx_ok = 32'(idx) < NumCounters;
    assign din    = 64'(data_i);
    // High-word regions only exist for a 32-bit port.
    assign access_err_o = (region > 3'd5) || (region == 3'd5 ? (idx != 5'd0) : !idx_ok) ||
                          ((DataWidth == 64) && (region == 3'd1 || region == 3'd4));
    assign wr = we_i && !access_err_o;

    // Event 0 and selects beyond the last event never count.
    always_comb begin
        for (int k = 0; k < NumCounters; k++)
            inc[k] = (sel_q[k] == '0 || 32'(sel_q[k]) >= NumEvents) ? '0 :
                     IncWidth'(event_inc_i >> (32'(sel_q[k]) * IncWidth));
    end

    always_comb begin
        sum     = '0;
        wrap_ev = '0;
        wrap_d  = wrap_q;
        for (int k = 0; k < NumCounters; k++) begin
            cnt_d[k] = cnt_q[k];
            sel_d[k] = sel_q[k];
            sum      = {1'b0, cnt_q[k]} + 65'(inc[k]);
            if (!debug_mode_i && !inhibit_i[k]) begin
                cnt_d[k]   = sum[63:0];
                wrap_ev[k] = sum[64];
            end
            // A register write replaces this cycle's increment (and its wrap).
            if (wr && idx == 5'(k) && region <= 3'd2) begin
                wrap_ev[k] = 1'b0;
                cnt_d[k]   = region == 3'd0 ? (DataWidth == 64 ? din : {cnt_q[k][63:32], din[31:0]}) :
                             region == 3'd1 ? {din[31:0], cnt_q[k][31:0]} : '0;
                if (region == 3'd2) sel_d[k] = din[SelW-1:0];
            end
        end
        if (wr && region == 3'd5) wrap_d &= ~din[NumCounters+15:16];
        wrap_d |= wrap_ev;
    end

    always_comb begin
        rd = '0;
        for (int k = 0; k < NumCounters; k++)
            if (idx == 5'(k))
                rd = region == 3'd0 ? cnt_q[k] :
                     region == 3'd1 ? {32'd0, cnt_q[k][63:32]} :
                     region == 3'd2 ? 64'(sel_q[k]) :
                     region == 3'd3 ? thr[k] :
                     region == 3'd4 ? {32'd0, thr[k][63:32]} : '0;
        if (region == 3'd5) rd = 64'(pend) | (64'(wrap_q) << 16);
    end
    assign data_o = access_err_o ? '0 : rd[DataWidth-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrap_q <= '0;
            for (int k = 0; k < NumCounters; k++) begin
                cnt_q[k] <= '0;
                sel_q[k] <= '0;
            end
        end else begin
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
        end
    end

`ifdef HPM_SAMPLING_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_e;

    state_e                 state_q;
    logic [63:0]            thr_q [NumCounters];
    logic [63:0]            thr_d [NumCounters];
    logic [NumCounters-1:0] pend_q, pend_d;
    logic                   valid_q, ack;
    logic [4:0]             id_q, low_id;
    logic [63:0]            value_q, low_val;
    logic [31:0]            hold_q;

    assign thr            = thr_q;
    assign pend           = pend_q;
    assign ack            = (state_q == REQ) && sample_ready_i;
    assign sample_valid_o = valid_q;
    assign sample_id_o    = id_q;
    assign sample_value_o = value_q;

    always_comb begin
        for (int k = 0; k < NumCounters; k++) begin
            thr_d[k] = thr_q[k];
            if (wr && idx == 5'(k) && region == 3'd3)
                thr_d[k] = DataWidth == 64 ? din : {thr_q[k][63:32], din[31:0]};
            if (wr && idx == 5'(k) && region == 3'd4)
                thr_d[k] = {din[31:0], thr_q[k][31:0]};
        end
    end

    // Clears first, then a fresh crossing in the same cycle wins.
    always_comb begin
        pend_d = pend_q;
        if (wr && region == 3'd5) pend_d &= ~din[NumCounters-1:0];
        for (int k = 0; k < NumCounters; k++) begin
            if (ack && id_q == 5'(k)) pend_d[k] = 1'b0;
            if (wr && region == 3'd2 && idx == 5'(k))
                pend_d[k] = 1'b0;
            else if (thr_q[k] != '0 &&
                     ((cnt_q[k] < thr_q[k] && cnt_d[k] >= thr_q[k]) || wrap_ev[k]))
                pend_d[k] = 1'b1;
        end
    end

    // Lowest pending index has priority.
    always_comb begin
        low_id  = '0;
        low_val = '0;
        for (int k = NumCounters - 1; k >= 0; k--)
            if (pend_q[k]) begin
                low_id  = 5'(k);
                low_val = cnt_q[k];
            end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            for (int k = 0; k < NumCounters; k++) thr_q[k] <= '0;
        end else begin
            pend_q <= pend_d;
            thr_q  <= thr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            value_q <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (|pend_q) begin
                    id_q    <= low_id;
                    value_q <= low_val;
                    valid_q <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (sample_ready_i) begin
                    valid_q <= 1'b0;
                    hold_q  <= 32'(HoldoffCycles) - 32'd1;
                    state_q <= (HoldoffCycles == 0) ? IDLE : HOLDOFF;
                end
                HOLDOFF: if (hold_q == '0) state_q <= IDLE;
                         else hold_q <= hold_q - 32'd1;
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unused_ready;

    assign unused_ready   = sample_ready_i;
    assign pend           = '0;
    assign sample_valid_o = 1'b0;
    assign sample_id_o    = '0;
    assign sample_value_o = '0;

    always_comb begin
        for (int k = 0; k < NumCounters; k++) thr[k] = '0;
    end
`endif
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: directed table-driven bench for hpm_counter_bank (default parameters).
module tb_hpm_counter_bank;
    localparam int NC = 6, NE = 32, IW = 2, DW = 64, HO = 4;
`ifdef HPM_SAMPLING_EN
    localparam bit SAMP = 1'b1;
`else
    localparam bit SAMP = 1'b0;
`endif

    logic           clk = 1'b0, rst = 1'b1, dbg = 1'b0, we = 1'b0, ready = 1'b0;
    logic [7:0]     addr = '0;
    logic [DW-1:0]  wdata = '0, rdata;
    logic           err, valid;
    logic [NE*IW-1:0] evin = '0;
    logic [NC-1:0]  inh = '0;
    logic [4:0]     sid;
    logic [63:0]    sval;

    hpm_counter_bank #(.NumCounters(NC), .NumEvents(NE), .IncWidth(IW), .DataWidth(DW),
                       .HoldoffCycles(HO)) dut (
        .clk_i(clk), .rst_i(rst), .debug_mode_i(dbg), .addr_i(addr), .we_i(we),
        .data_i(wdata), .data_o(rdata), .access_err_o(err), .event_inc_i(evin),
        .inhibit_i(inh), .sample_valid_o(valid), .sample_ready_i(ready),
        .sample_id_o(sid), .sample_value_o(sval));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [63:0] data;
        logic [63:0] ev;
        logic [5:0]  inh;
        logic        dbg;
        logic [63:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0, n_bad = 0;

    function automatic logic [7:0] A(input int r, input int i);
        logic [7:0] a;
        a = {r[2:0], i[4:0]};
        return a;
    endfunction

    function automatic logic [63:0] ev(input int e, input int v);
        return 64'(v) << (2 * e);
    endfunction

    function automatic void add(input logic [7:0] a, input logic w, input logic [63:0] d,
                                input logic [63:0] e, input logic [5:0] ih, input logic dg,
                                input logic [63:0] xd, input logic xe);
        vec_t v;
        v.addr = a; v.we = w; v.data = d; v.ev = e; v.inh = ih; v.dbg = dg;
        v.exp_d = xd; v.exp_e = xe;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic w, input logic [63:0] d, input logic [63:0] e);
        @(negedge clk);
        addr = a; we = w; wdata = d; evin = e; inh = '0; dbg = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // counting, inhibit, debug
        add(A(0,0), 0, 0, 0, 0, 0, 0, 0);
        add(A(2,0), 1, 3, 0, 0, 0, 0, 0);
        add(A(2,0), 0, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 10; i++) add(A(0,0), 0, 0, ev(3,2), 0, 0, 64'(2*i), 0);
        add(A(0,0), 1, 0, 0, 0, 0, 20, 0);
        for (int i = 0; i < 10; i++)
            add(A(0,0), 0, 0, ev(3,2), (i >= 5) ? 6'd1 : 6'd0, 0, (i < 5) ? 64'(2*i) : 64'd10, 0);
        for (int i = 0; i < 3; i++) add(A(0,0), 0, 0, ev(3,2), 0, 1, 10, 0);
        add(A(0,0), 0, 0, 0, 0, 0, 10, 0);
        // write collides with increment; max increment
        add(A(2,1), 1, 5, ev(5,3), 0, 0, 0, 0);
        add(A(0,1), 1, 64'h100, ev(5,3), 0, 0, 0, 0);
        add(A(0,1), 0, 0, ev(5,3), 0, 0, 64'h100, 0);
        add(A(0,1), 0, 0, 0, 0, 0, 64'h103, 0);
        // wrap and write-1-to-clear
        add(A(2,2), 1, 1, 0, 0, 0, 0, 0);
        add(A(0,2), 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
        add(A(0,2), 0, 0, ev(1,1), 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(A(0,2), 0, 0, 0, 0, 0, 0, 0);
        add(A(5,0), 0, 0, 0, 0, 0, 64'h40000, 0);
        add(A(5,1), 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1);
        add(A(5,0), 1, 64'h40000, 0, 0, 0, 64'h40000, 0);
        add(A(5,0), 0, 0, 0, 0, 0, 0, 0);
        // access errors leave state alone
        add(A(1,0), 1, 64'hDEAD, 0, 0, 0, 0, 1);
        add(A(0,7), 1, 64'h77, 0, 0, 0, 0, 1);
        add(A(6,0), 1, 1, 0, 0, 0, 0, 1);
        add(A(7,31), 0, 0, 0, 0, 0, 0, 1);
        add(A(2,6), 0, 0, 0, 0, 0, 0, 1);
        add(A(0,5), 0, 0, 0, 0, 0, 0, 0);
        add(A(0,0), 0, 0, 0, 0, 0, 10, 0);
        // event 0 never counts
        add(A(0,3), 0, 0, ev(0,3), 0, 0, 0, 0);
        add(A(0,3), 0, 0, 0, 0, 0, 0, 0);
        // threshold region
        add(A(3,0), 1, 5, 0, 0, 0, 0, 0);
        add(A(3,0), 0, 0, 0, 0, 0, SAMP ? 64'd5 : 64'd0, 0);
        add(A(5,0), 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].data;
            evin = vecs[i].ev; inh = vecs[i].inh; dbg = vecs[i].dbg;
            #1;
            chk("vec_data", i, 64'(rdata), vecs[i].exp_d);
            chk("vec_err", i, 64'(err), 64'(vecs[i].exp_e));
        end
        drive(A(0,0), 0, 0, 0);
        #1 chk("idle_valid", 0, 64'(valid), 0);

`ifdef HPM_SAMPLING_EN
        drive(A(2,0), 1, 3, 0);
        drive(A(2,4), 1, 3, 0);
        drive(A(3,0), 1, 5, 0);
        drive(A(3,4), 1, 5, 0);
        repeat (5) drive(A(0,0), 0, 0, ev(3,1));
        drive(A(0,0), 0, 0, 0);
        #1 chk("cross_valid_lo", 0, 64'(valid), 0);
        chk("cross_cnt", 0, 64'(rdata), 5);
        @(negedge clk);
        #1 chk("req_valid", 0, 64'(valid), 1);
        chk("req_id", 0, 64'(sid), 0);
        chk("req_value", 0, sval, 5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1 chk("hold_valid", i, 64'(valid), 1);
            chk("hold_id", i, 64'(sid), 0);
            chk("hold_value", i, sval, 5);
        end
        ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            ready = 1'b0;
            n++;
            #1;
            if (valid) break;
        end
        chk("gap", 0, 64'(n), HO + 2);
        chk("req2_id", 0, 64'(sid), 4);
        chk("req2_value", 0, sval, 5);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        addr = A(5,0);
        #1 chk("ack2_valid", 0, 64'(valid), 0);
        chk("pend_clear", 0, 64'(rdata), 0);
        drive(A(0,0), 1, 4, 0);
        drive(A(0,0), 0, 0, ev(3,1));
        drive(A(0,0), 0, 0, 0);
        n = 0;
        while (n < 20 && !valid) begin
            @(negedge clk);
            n++;
        end
        #1 chk("req3_valid", 0, 64'(valid), 1);
`endif

        @(negedge clk);
        addr = A(0,0); we = 1'b0; evin = '0;
        #1 chk("pre_rst_cnt0", 0, 64'(rdata), SAMP ? 64'd5 : 64'd10);
        #1 rst = 1'b1;
        #1 chk("rst_valid", 0, 64'(valid), 0);
        chk("rst_cnt0", 0, 64'(rdata), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NC; k++) begin
            addr = A(0,k);
            #1 chk("post_rst_cnt", k, 64'(rdata), 0);
            addr = A(2,k);
            #1 chk("post_rst_sel", k, 64'(rdata), 0);
        end
        addr = A(5,0);
        #1 chk("post_rst_status", 0, 64'(rdata), 0);
        chk("post_rst_id", 0, 64'(sid), 0);
        chk("post_rst_value", 0, sval, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
